// File: rtl/dlh_bank_if.sv
// Data/gate/clear inputs and held-value/violation outputs of a dlh_bank.
// The master side drives the gates, the slave side (the bank) answers.
interface dlh_bank_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int VCW   = 8
);
  logic [NCH*WIDTH-1:0] D;
  logic [NCH-1:0]       G;
  logic                 CLR;
  logic [NCH*WIDTH-1:0] Q;
  logic [NCH*WIDTH-1:0] QN;
  logic [NCH-1:0]       VIOL;
  logic                 NOTIFY;
  logic [VCW-1:0]       VCNT;

  modport master (output D, G, CLR, input Q, QN, VIOL, NOTIFY, VCNT);
  modport slave  (input D, G, CLR, output Q, QN, VIOL, NOTIFY, VCNT);
endinterface

// File: rtl/dlh_bank.sv
// Multi-channel gated hold register with a minimum gate-pulse-width check.
// Each channel tracks its pulse length; short pulses are flagged and either dropped or committed.
module dlh_bank #(
  parameter int WIDTH        = 8,
  parameter int NCH          = 4,
  parameter int MIN_WIDTH    = 2,
  parameter bit REJECT_SHORT = 1'b1,
  parameter int VCW          = 8
) (
  input  logic       CK,
  input  logic       RN,
  dlh_bank_if.slave  bus
);
  localparam int CW = $clog2(MIN_WIDTH + 1);
  localparam int PW = $clog2(NCH + 1);
  localparam int SW = ((VCW > PW) ? VCW : PW) + 1;

  logic [WIDTH-1:0] s_q   [NCH];
  logic [WIDTH-1:0] s_d   [NCH];
  logic [WIDTH-1:0] p_q   [NCH];
  logic [WIDTH-1:0] p_d   [NCH];
  logic [CW-1:0]    cnt_q [NCH];
  logic [CW-1:0]    cnt_d [NCH];
  logic [NCH-1:0]   g_q;
  logic [NCH-1:0]   viol_q, viol_d;
  logic             notify_q, notify_d;
  logic [VCW-1:0]   vcnt_q, vcnt_d;

  logic [NCH-1:0]   viol_ev;
  logic [PW-1:0]    nviol;
  logic [CW:0]      inc;
  logic [SW-1:0]    sum;
  logic [NCH*WIDTH-1:0] q_flat;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    viol_ev = '0;
    nviol   = '0;
    inc     = '0;
    for (int i = 0; i < NCH; i++) begin
      s_d[i]   = s_q[i];
      p_d[i]   = p_q[i];
      cnt_d[i] = cnt_q[i];
      if (bus.G[i]) begin
        inc    = (CW+1)'(cnt_q[i]) + (CW+1)'(1);
        p_d[i] = bus.D[i*WIDTH +: WIDTH];
        if (inc >= (CW+1)'(MIN_WIDTH)) begin
          cnt_d[i] = CW'(MIN_WIDTH);
          s_d[i]   = bus.D[i*WIDTH +: WIDTH];
        end else begin
          cnt_d[i] = inc[CW-1:0];
        end
      end else begin
        cnt_d[i] = '0;
        // A close before the counter reached MIN_WIDTH is a short pulse.
        if (g_q[i] && ((CW+1)'(cnt_q[i]) < (CW+1)'(MIN_WIDTH))) begin
          viol_ev[i] = 1'b1;
          if (!REJECT_SHORT) s_d[i] = p_q[i];
        end
      end
      nviol = nviol + PW'(viol_ev[i]);
    end

    notify_d = |viol_ev;
    if (bus.CLR) begin
      viol_d = viol_ev;
      sum    = SW'(nviol);
    end else begin
      viol_d = viol_q | viol_ev;
      sum    = SW'(vcnt_q) + SW'(nviol);
    end
    vcnt_d = (sum > SW'({VCW{1'b1}})) ? {VCW{1'b1}} : sum[VCW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      // NOTE: the per-channel arrays are small register files, reset element by element
      // so a reset mid-pulse leaves no trace of the old pulse.
      for (int i = 0; i < NCH; i++) begin
        s_q[i]   <= '0;
        p_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
      g_q      <= '0;
      viol_q   <= '0;
      notify_q <= 1'b0;
      vcnt_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        s_q[i]   <= s_d[i];
        p_q[i]   <= p_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      g_q      <= bus.G;
      viol_q   <= viol_d;
      notify_q <= notify_d;
      vcnt_q   <= vcnt_d;
    end
  end

  always_comb begin
    q_flat = '0;
    for (int i = 0; i < NCH; i++) q_flat[i*WIDTH +: WIDTH] = s_q[i];
  end

  assign bus.Q      = q_flat;
  assign bus.QN     = ~q_flat;
  assign bus.VIOL   = viol_q;
  assign bus.NOTIFY = notify_q;
  assign bus.VCNT   = vcnt_q;
endmodule
